// File: rtl/wdb_fill_agent_pkg.sv
// Shared widths and payload types for the WDB fill agent.
// Optional length checking in the agent is enabled with WDB_FILL_LEN_CHK_EN.
package wdb_fill_agent_pkg;

    localparam int US_BEAT_WIDTH        = 256;
    localparam int US_BEATS_PER_LINE    = 4;
    localparam int DATA_WIDTH           = 1024;
    localparam int DB_ENTRY_IDX_WIDTH   = 4;
    localparam int MSHR_ENTRY_IDX_WIDTH = 4;

    typedef struct packed {
        logic [US_BEAT_WIDTH-1:0]        data;
        logic                            last;
        logic [MSHR_ENTRY_IDX_WIDTH-1:0] rob_entry_id;
    } us_wdata_pld_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0]         data;
        logic [DB_ENTRY_IDX_WIDTH-1:0] db_entry_id;
    } wdb_pld_t;

    typedef struct packed {
        logic [MSHR_ENTRY_IDX_WIDTH-1:0] rob_id;
        logic [DB_ENTRY_IDX_WIDTH-1:0]   db_id;
    } wdata_done_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_WRITE   = 2'd2
    } fill_state_e;

endpackage

// File: rtl/wdb_fill_agent.sv
// Collects US write-data beats into one WDB line, writes it to the WDB and signals completion.
// Define WDB_FILL_LEN_CHK_EN to enable the sticky 'last' framing check on err_len.
module wdb_fill_agent
    import wdb_fill_agent_pkg::*;
#(
    parameter int BEAT_WIDTH = US_BEAT_WIDTH,
    parameter int LINE_WIDTH = DATA_WIDTH,
    parameter int BEATS      = US_BEATS_PER_LINE
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            us_wdata_vld,
    input  us_wdata_pld_t                   us_wdata_pld,
    output logic                            us_wdata_rdy,
    input  logic                            alloc_vld,
    input  logic [DB_ENTRY_IDX_WIDTH-1:0]   alloc_idx,
    output logic                            alloc_rdy,
    output logic                            write_wdb_vld,
    output wdb_pld_t                        write_wdb_pld,
    input  logic                            write_wdb_rdy,
    output logic                            wdata_done,
    output logic [MSHR_ENTRY_IDX_WIDTH-1:0] wdata_done_rob_id,
    output logic [DB_ENTRY_IDX_WIDTH-1:0]   wdata_done_db_id,
    output logic                            err_len
);

    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    if (BEATS * BEAT_WIDTH != LINE_WIDTH) begin : g_bad_beats
        $error("wdb_fill_agent: BEATS must equal LINE_WIDTH/BEAT_WIDTH");
    end
    if (BEAT_WIDTH != US_BEAT_WIDTH || LINE_WIDTH != DATA_WIDTH) begin : g_bad_widths
        $error("wdb_fill_agent: widths must match the package payload types");
    end

    fill_state_e                     state_q, state_d;
    logic [CNT_W-1:0]                beat_cnt_q, beat_cnt_d;
    logic [LINE_WIDTH-1:0]           line_q, line_d;
    logic [DB_ENTRY_IDX_WIDTH-1:0]   db_id_q, db_id_d;
    logic [MSHR_ENTRY_IDX_WIDTH-1:0] rob_id_q, rob_id_d;
    logic                            done_q, done_d;
    wdata_done_t                     done_info_q, done_info_d;
    logic                            beat_acc;
    logic                            last_beat;

    assign beat_acc  = (state_q == ST_COLLECT) && us_wdata_vld;
    assign last_beat = (beat_cnt_q == CNT_W'(BEATS - 1));

    always_comb begin
        state_d     = state_q;
        beat_cnt_d  = beat_cnt_q;
        line_d      = line_q;
        db_id_d     = db_id_q;
        rob_id_d    = rob_id_q;
        done_d      = 1'b0;
        done_info_d = done_info_q;
        case (state_q)
            ST_IDLE: begin
                if (alloc_vld) begin
                    db_id_d = alloc_idx;
                    state_d = ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                if (us_wdata_vld) begin
                    for (int k = 0; k < BEATS; k++) begin
                        if (beat_cnt_q == CNT_W'(k)) begin
                            line_d[k*BEAT_WIDTH +: BEAT_WIDTH] = us_wdata_pld.data;
                        end
                    end
                    if (beat_cnt_q == '0) begin
                        rob_id_d = us_wdata_pld.rob_entry_id;
                    end
                    if (last_beat) begin
                        beat_cnt_d = '0;
                        state_d    = ST_WRITE;
                    end else begin
                        beat_cnt_d = beat_cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_WRITE: begin
                if (write_wdb_rdy) begin
                    done_d      = 1'b1;
                    done_info_d = '{rob_id: rob_id_q, db_id: db_id_q};
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Done is registered so the WDB array write lands before the MSHR can arbitrate the line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            beat_cnt_q  <= '0;
            line_q      <= '0;
            db_id_q     <= '0;
            rob_id_q    <= '0;
            done_q      <= 1'b0;
            done_info_q <= '0;
        end else begin
            state_q     <= state_d;
            beat_cnt_q  <= beat_cnt_d;
            line_q      <= line_d;
            db_id_q     <= db_id_d;
            rob_id_q    <= rob_id_d;
            done_q      <= done_d;
            done_info_q <= done_info_d;
        end
    end

`ifdef WDB_FILL_LEN_CHK_EN
    logic err_len_q;

    // Framing errors are only flagged; the line still closes on beat count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_len_q <= 1'b0;
        end else if (beat_acc && (us_wdata_pld.last != last_beat)) begin
            err_len_q <= 1'b1;
        end
    end

    assign err_len = err_len_q;
`else
    logic unused_last;
    logic unused_beat_acc;
    assign unused_last     = us_wdata_pld.last;
    assign unused_beat_acc = beat_acc;
    assign err_len         = 1'b0;
`endif

    // Ready outputs are masked by rst_n so nothing is offered while reset is held.
    assign alloc_rdy         = rst_n && (state_q == ST_IDLE);
    assign us_wdata_rdy      = rst_n && (state_q == ST_COLLECT);
    assign write_wdb_vld     = (state_q == ST_WRITE);
    assign write_wdb_pld     = '{data: line_q, db_entry_id: db_id_q};
    assign wdata_done        = done_q;
    assign wdata_done_rob_id = done_info_q.rob_id;
    assign wdata_done_db_id  = done_info_q.db_id;

endmodule

// File: tb/tb_wdb_fill_agent.sv
// Scoreboard bench for wdb_fill_agent: directed lines, backpressure, gaps, reset and framing check.
module tb_wdb_fill_agent;
    import wdb_fill_agent_pkg::*;

    logic                            clk;
    logic                            rst_n;
    logic                            us_wdata_vld;
    us_wdata_pld_t                   us_wdata_pld;
    logic                            us_wdata_rdy;
    logic                            alloc_vld;
    logic [DB_ENTRY_IDX_WIDTH-1:0]   alloc_idx;
    logic                            alloc_rdy;
    logic                            write_wdb_vld;
    wdb_pld_t                        write_wdb_pld;
    logic                            write_wdb_rdy;
    logic                            wdata_done;
    logic [MSHR_ENTRY_IDX_WIDTH-1:0] wdata_done_rob_id;
    logic [DB_ENTRY_IDX_WIDTH-1:0]   wdata_done_db_id;
    logic                            err_len;

    wdb_fill_agent dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .us_wdata_vld     (us_wdata_vld),
        .us_wdata_pld     (us_wdata_pld),
        .us_wdata_rdy     (us_wdata_rdy),
        .alloc_vld        (alloc_vld),
        .alloc_idx        (alloc_idx),
        .alloc_rdy        (alloc_rdy),
        .write_wdb_vld    (write_wdb_vld),
        .write_wdb_pld    (write_wdb_pld),
        .write_wdb_rdy    (write_wdb_rdy),
        .wdata_done       (wdata_done),
        .wdata_done_rob_id(wdata_done_rob_id),
        .wdata_done_db_id (wdata_done_db_id),
        .err_len          (err_len)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    wdb_pld_t    exp_wq[$];
    wdata_done_t exp_dq[$];
    logic        hs_prev = 1'b0;

    task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] fold(input logic [DATA_WIDTH-1:0] d);
        logic [63:0] r = '0;
        for (int i = 0; i < DATA_WIDTH / 64; i++) r = r ^ (d[i*64 +: 64] << (i % 8));
        return r;
    endfunction

    function automatic logic [US_BEAT_WIDTH-1:0] pat(input logic [3:0] nib);
        return {64{nib}};
    endfunction

    // Monitor: pops and compares on every write handshake and every done pulse.
    always @(negedge clk) begin
        if (!rst_n) begin
            hs_prev = 1'b0;
        end else begin
            if (wdata_done) begin
                check(hs_prev, "done_timing", 64'(wdata_done), 64'(hs_prev));
                if (exp_dq.size() == 0) begin
                    check(1'b0, "done_unexpected", 64'(wdata_done_db_id), 64'hffff);
                end else begin
                    wdata_done_t e;
                    e = exp_dq.pop_front();
                    check(wdata_done_rob_id == e.rob_id, "done_rob", 64'(wdata_done_rob_id), 64'(e.rob_id));
                    check(wdata_done_db_id == e.db_id, "done_db", 64'(wdata_done_db_id), 64'(e.db_id));
                end
            end else if (hs_prev) begin
                check(1'b0, "done_missing", 64'(wdata_done), 64'd1);
            end
            hs_prev = write_wdb_vld && write_wdb_rdy;
            if (hs_prev) begin
                if (exp_wq.size() == 0) begin
                    check(1'b0, "write_unexpected", 64'(write_wdb_pld.db_entry_id), 64'hffff);
                end else begin
                    wdb_pld_t e;
                    e = exp_wq.pop_front();
                    check(write_wdb_pld.data == e.data, "write_data", fold(write_wdb_pld.data), fold(e.data));
                    check(write_wdb_pld.db_entry_id == e.db_entry_id, "write_db_id",
                          64'(write_wdb_pld.db_entry_id), 64'(e.db_entry_id));
                end
            end
        end
    end

    task automatic do_alloc(input logic [DB_ENTRY_IDX_WIDTH-1:0] idx);
        int n = 0;
        alloc_vld = 1'b1;
        alloc_idx = idx;
        @(negedge clk);
        while (!alloc_rdy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check(1'b0, "alloc_timeout", 64'(alloc_rdy), 64'd1);
        @(posedge clk);
        #1;
        alloc_vld = 1'b0;
    endtask

    task automatic send_beat(input logic [US_BEAT_WIDTH-1:0] d, input logic last,
                             input logic [MSHR_ENTRY_IDX_WIDTH-1:0] rob);
        int n = 0;
        us_wdata_vld = 1'b1;
        us_wdata_pld = '{data: d, last: last, rob_entry_id: rob};
        @(negedge clk);
        while (!us_wdata_rdy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check(1'b0, "beat_timeout", 64'(us_wdata_rdy), 64'd1);
        @(posedge clk);
        #1;
        us_wdata_vld = 1'b0;
    endtask

    task automatic gap();
        us_wdata_vld = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [DB_ENTRY_IDX_WIDTH-1:0] idx, input logic [MSHR_ENTRY_IDX_WIDTH-1:0] rob,
                            input logic [3:0] n0, input logic [3:0] n1, input logic [3:0] n2, input logic [3:0] n3);
        exp_wq.push_back('{data: {pat(n3), pat(n2), pat(n1), pat(n0)}, db_entry_id: idx});
        exp_dq.push_back('{rob_id: rob, db_id: idx});
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_wq.size() != 0 || exp_dq.size() != 0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check(n < 100, "drain", 64'(exp_wq.size() + exp_dq.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        wdb_pld_t held;
        rst_n         = 1'b0;
        us_wdata_vld  = 1'b0;
        us_wdata_pld  = '0;
        alloc_vld     = 1'b0;
        alloc_idx     = '0;
        write_wdb_rdy = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        check(alloc_rdy == 1'b0, "rst_alloc_rdy", 64'(alloc_rdy), 64'd0);
        check(us_wdata_rdy == 1'b0, "rst_us_rdy", 64'(us_wdata_rdy), 64'd0);
        check(write_wdb_vld == 1'b0, "rst_write_vld", 64'(write_wdb_vld), 64'd0);
        check(wdata_done == 1'b0 && err_len == 1'b0, "rst_done_err", 64'({wdata_done, err_len}), 64'd0);
        check(write_wdb_pld == '0, "rst_line", fold(write_wdb_pld.data), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check(alloc_rdy == 1'b1, "idle_alloc_rdy", 64'(alloc_rdy), 64'd1);
        @(posedge clk);
        #1;

        // 1: single line; rob must come from beat 0 only
        do_alloc(4'd5);
        send_beat(pat(4'hA), 1'b0, 4'd3);
        send_beat(pat(4'hB), 1'b0, 4'd7);
        send_beat(pat(4'hC), 1'b0, 4'd7);
        push_exp(4'd5, 4'd3, 4'hA, 4'hB, 4'hC, 4'hD);
        send_beat(pat(4'hD), 1'b1, 4'd7);
        @(negedge clk);
        check(write_wdb_vld == 1'b1, "t1_write_next_cycle", 64'(write_wdb_vld), 64'd1);
        check(alloc_rdy == 1'b0, "t1_no_alloc_in_write", 64'(alloc_rdy), 64'd0);
        drain();

        // 2: write backpressure for 7 cycles
        write_wdb_rdy = 1'b0;
        do_alloc(4'd4);
        send_beat(pat(4'h1), 1'b0, 4'd1);
        send_beat(pat(4'h2), 1'b0, 4'd1);
        send_beat(pat(4'h3), 1'b0, 4'd1);
        push_exp(4'd4, 4'd1, 4'h1, 4'h2, 4'h3, 4'h4);
        held = exp_wq[0];
        send_beat(pat(4'h4), 1'b1, 4'd1);
        repeat (7) begin
            @(negedge clk);
            check(write_wdb_vld == 1'b1, "t2_vld_held", 64'(write_wdb_vld), 64'd1);
            check(write_wdb_pld == held, "t2_pld_stable", fold(write_wdb_pld.data), fold(held.data));
            check(us_wdata_rdy == 1'b0 && wdata_done == 1'b0, "t2_quiet",
                  64'({us_wdata_rdy, wdata_done}), 64'd0);
        end
        @(posedge clk);
        #1;
        write_wdb_rdy = 1'b1;
        drain();

        // 3: beat gaps, vld pattern 1,0,0,1,1,0,1
        do_alloc(4'd12);
        send_beat(pat(4'h6), 1'b0, 4'd6);
        gap();
        gap();
        send_beat(pat(4'h7), 1'b0, 4'd2);
        send_beat(pat(4'h8), 1'b0, 4'd2);
        gap();
        check(write_wdb_vld == 1'b0, "t3_no_early_write", 64'(write_wdb_vld), 64'd0);
        push_exp(4'd12, 4'd6, 4'h6, 4'h7, 4'h8, 4'h9);
        send_beat(pat(4'h9), 1'b1, 4'd2);
        @(negedge clk);
        check(write_wdb_vld == 1'b1, "t3_write_after_4th", 64'(write_wdb_vld), 64'd1);
        drain();

        // 4: no alloc while US data is offered
        us_wdata_vld = 1'b1;
        us_wdata_pld = '{data: pat(4'hF), last: 1'b1, rob_entry_id: 4'd15};
        repeat (10) begin
            @(negedge clk);
            check(us_wdata_rdy == 1'b0 && write_wdb_vld == 1'b0, "t4_idle_blocks_us",
                  64'({us_wdata_rdy, write_wdb_vld}), 64'd0);
        end
        @(posedge clk);
        #1;
        us_wdata_vld = 1'b0;

        // 5: back-to-back lines; first done overlaps the second alloc
        do_alloc(4'd2);
        send_beat(pat(4'hE), 1'b0, 4'd8);
        send_beat(pat(4'hF), 1'b0, 4'd8);
        send_beat(pat(4'h1), 1'b0, 4'd8);
        push_exp(4'd2, 4'd8, 4'hE, 4'hF, 4'h1, 4'h2);
        send_beat(pat(4'h2), 1'b1, 4'd8);
        do_alloc(4'd9);
        send_beat(pat(4'h5), 1'b0, 4'd10);
        send_beat(pat(4'h6), 1'b0, 4'd10);
        send_beat(pat(4'h7), 1'b0, 4'd10);
        push_exp(4'd9, 4'd10, 4'h5, 4'h6, 4'h7, 4'h8);
        send_beat(pat(4'h8), 1'b1, 4'd10);
        drain();

        // 6: reset mid-line, then a fresh line with last on beat 1
        check(err_len == 1'b0, "t6_no_err_yet", 64'(err_len), 64'd0);
        do_alloc(4'd7);
        send_beat(pat(4'h3), 1'b0, 4'd4);
        send_beat(pat(4'h3), 1'b0, 4'd4);
        rst_n = 1'b0;
        #1;
        check({alloc_rdy, us_wdata_rdy, write_wdb_vld, wdata_done, err_len} == 5'b0, "t6_rst_outputs",
              64'({alloc_rdy, us_wdata_rdy, write_wdb_vld, wdata_done, err_len}), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        do_alloc(4'd11);
        send_beat(pat(4'hC), 1'b0, 4'd13);
        send_beat(pat(4'h0), 1'b1, 4'd1);
`ifdef WDB_FILL_LEN_CHK_EN
        check(err_len == 1'b1, "t6_err_set", 64'(err_len), 64'd1);
`else
        check(err_len == 1'b0, "t6_err_tied", 64'(err_len), 64'd0);
`endif
        send_beat(pat(4'h5), 1'b0, 4'd1);
        push_exp(4'd11, 4'd13, 4'hC, 4'h0, 4'h5, 4'hB);
        send_beat(pat(4'hB), 1'b1, 4'd1);
        drain();
        repeat (3) @(posedge clk);
        #1;
`ifdef WDB_FILL_LEN_CHK_EN
        check(err_len == 1'b1, "t6_err_sticky", 64'(err_len), 64'd1);
`else
        check(err_len == 1'b0, "t6_err_still_0", 64'(err_len), 64'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
